three_one_mux_reg: RTL and testbench



---
 rtl/three_one_mux_reg.sv | 92 +++++++++
 tb/tb_three_one_mux_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/three_one_mux_reg.sv
// 3:1 datapath mux with a combinational output and a valid-qualified registered output.
// Optional `THREE_ONE_MUX_ERR_CNT_EN adds err_cnt, a saturating count of illegal-select beats.
module three_one_mux_reg #(
   parameter int unsigned size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [size-1:0] in0,
   input  logic [size-1:0] in1,
   input  logic [size-1:0] in2,
   input  logic [1:0]      select,
   input  logic            in_valid,
   output logic [size-1:0] out_comb,
   output logic [size-1:0] out,
   output logic            out_valid,
   output logic            sel_err
`ifdef THREE_ONE_MUX_ERR_CNT_EN
   ,
   output logic [7:0]      err_cnt
`endif
);

   logic [size-1:0] mux_val;
   logic            sel_illegal;

   logic [size-1:0] out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            sel_err_q, sel_err_d;

   assign sel_illegal = (select == 2'b11);

   // Illegal select drives zero so neither path can ever show X.
   always_comb begin
      mux_val = '0;
      case (select)
         2'b00:   mux_val = in0;
         2'b01:   mux_val = in1;
         2'b10:   mux_val = in2;
         default: mux_val = '0;
      endcase
   end

   assign out_comb = mux_val;

   always_comb begin
      out_d       = out_q;
      out_valid_d = in_valid;
      sel_err_d   = 1'b0;
      if (in_valid) begin
         out_d     = mux_val;
         sel_err_d = sel_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign sel_err   = sel_err_q;

`ifdef THREE_ONE_MUX_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (in_valid && sel_illegal && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_three_one_mux_reg.sv
// Self-checking bench for three_one_mux_reg: directed cases plus randomized beats
// against an array-indexed reference model.
module tb_three_one_mux_reg;

   localparam int unsigned SIZE = 4;

   logic            clk;
   logic            rst_n;
   logic [SIZE-1:0] in0, in1, in2;
   logic [1:0]      select;
   logic            in_valid;
   logic [SIZE-1:0] out_comb;
   logic [SIZE-1:0] out;
   logic            out_valid;
   logic            sel_err;
`ifdef THREE_ONE_MUX_ERR_CNT_EN
   logic [7:0]      err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [SIZE-1:0] m_out;
   logic            m_valid;
   logic            m_err;
   int              m_cnt;

   three_one_mux_reg #(.size(SIZE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in0      (in0),
      .in1      (in1),
      .in2      (in2),
      .select   (select),
      .in_valid (in_valid),
      .out_comb (out_comb),
      .out      (out),
      .out_valid(out_valid),
      .sel_err  (sel_err)
`ifdef THREE_ONE_MUX_ERR_CNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] ref_mux(input logic [1:0] s, input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] b,
                                               input logic [SIZE-1:0] c);
      logic [SIZE-1:0] srcs [3];
      srcs[0] = a;
      srcs[1] = b;
      srcs[2] = c;
      if (s == 2'd3) return '0;
      return srcs[s];
   endfunction

   task automatic model_reset();
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".out"}, 64'(out), 64'(m_out));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
`ifdef THREE_ONE_MUX_ERR_CNT_EN
      check({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_cnt));
`endif
   endtask

   // Called at a negedge: drive one beat, check comb path, clock it, check registered path.
   task automatic beat(input string tag, input logic v, input logic [1:0] s,
                       input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input logic [SIZE-1:0] c, input bit chk_regs);
      logic [SIZE-1:0] r;
      in_valid = v;
      select   = s;
      in0      = a;
      in1      = b;
      in2      = c;
      #1;
      r = ref_mux(s, a, b, c);
      check({tag, ".comb"}, 64'(out_comb), 64'(r));
      m_valid = v;
      if (v) begin
         m_out = r;
         m_err = (s == 2'd3);
         if (s == 2'd3 && m_cnt < 255) m_cnt++;
      end else begin
         m_err = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (chk_regs) check_regs(tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      select   = 2'd0;
      in0      = 4'b0011;
      in1      = 4'b1100;
      in2      = 4'b1010;
      model_reset();
      #1;
      check_regs("reset");
      check("reset_comb", 64'(out_comb), 64'(4'b0011));

      // Combinational select stepping
      select = 2'd1; #1; check("comb_s1", 64'(out_comb), 64'(4'b1100));
      select = 2'd2; #1; check("comb_s2", 64'(out_comb), 64'(4'b1010));
      in0 = 4'b1111; in1 = 4'b0000; in2 = 4'b0101;
      #1; check("comb_hold_s2", 64'(out_comb), 64'(4'b0101));
      select = 2'd0; #1; check("comb_s0", 64'(out_comb), 64'(4'b1111));
      select = 2'd1; #1; check("comb_s1b", 64'(out_comb), 64'(4'b0000));
      select = 2'd3; #1; check("comb_s3", 64'(out_comb), 64'(4'b0000));

      @(negedge clk);
      rst_n = 1'b1;

      beat("load1", 1'b1, 2'd1, 4'b0011, 4'b1100, 4'b1010, 1'b1);
      check("load1_out", 64'(out), 64'(4'b1100));
      beat("idle", 1'b0, 2'd0, 4'b0111, 4'b0001, 4'b0010, 1'b1);
      check("idle_hold", 64'(out), 64'(4'b1100));
      beat("illegal", 1'b1, 2'd3, 4'b1111, 4'b1111, 4'b1111, 1'b1);
      check("illegal_err", 64'(sel_err), 64'(1));
      beat("after_ill", 1'b1, 2'd0, 4'b0110, 4'b0000, 4'b0000, 1'b1);
      check("err_one_cycle", 64'(sel_err), 64'(0));

      // Mid-cycle changes with in_valid=0 must not reach out
      in_valid = 1'b0; select = 2'd2; in2 = 4'b1001;
      #2; check("between_edges", 64'(out), 64'(4'b0110));

      for (int i = 0; i < 200; i++) begin
         beat("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      end

`ifdef THREE_ONE_MUX_ERR_CNT_EN
      for (int i = 0; i < 300; i++) begin
         beat("sat", 1'b1, 2'd3, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end
      check_regs("sat_end");
      check("sat_255", 64'(err_cnt), 64'(255));
`endif

      // Asynchronous reset between edges
      beat("pre_rst", 1'b1, 2'd2, 4'b0000, 4'b0000, 4'b1010, 1'b1);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs("async_rst");
      select = 2'd0; in0 = 4'b1101;
      #1; check("rst_comb", 64'(out_comb), 64'(4'b1101));
      @(negedge clk);
      check_regs("rst_held");
      rst_n = 1'b1;
      beat("post_rst", 1'b1, 2'd1, 4'b0001, 4'b0110, 4'b0011, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
